// File: rtl/fadd_stream_acc.sv
// Streaming FP accumulator: folds adder-tree beats into one sum per packet and queues results in a FWFT FIFO.
// Optional define FADD_ACC_CNT_EN adds the per-packet beat counter, the FIFO count field and the out_cnt port.

module fp_add #(
  parameter int sig_width = 7,
  parameter int exp_width = 8
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);
  localparam int DW = sig_width + exp_width + 1;
  localparam int MW = sig_width + 1;  // mantissa including hidden bit
  localparam int XW = MW + 3;         // plus guard, round and sticky
  localparam logic [exp_width-1:0] EXP_ONE = {{(exp_width-1){1'b0}}, 1'b1};
  localparam logic [exp_width-1:0] EXP_MAX = '1;
  localparam logic [exp_width:0]   EXN_ONE = {{exp_width{1'b0}}, 1'b1};
  localparam logic [exp_width:0]   EXN_MAX = {1'b0, EXP_MAX};

  logic                 swap, sign_l, sign_s, eff_sub;
  logic [exp_width-1:0] exp_l, exp_s, eff_exp_l, eff_exp_s, shift;
  logic [sig_width-1:0] frac_l, frac_s;
  logic [XW-1:0]        ext_l, ext_s, aligned, norm;
  logic                 sticky, guard, rs, inexact, round_up;
  logic [XW:0]          sum_raw;
  logic [exp_width:0]   exp_n, exp_r;
  logic [MW:0]          rounded;
  logic                 a_nan, b_nan, a_inf, b_inf;

  assign a_nan = (&a[DW-2:sig_width]) && (|a[sig_width-1:0]);
  assign b_nan = (&b[DW-2:sig_width]) && (|b[sig_width-1:0]);
  assign a_inf = (&a[DW-2:sig_width]) && (a[sig_width-1:0] == '0);
  assign b_inf = (&b[DW-2:sig_width]) && (b[sig_width-1:0] == '0);

  // Order operands by magnitude so the subtraction below never goes negative.
  assign swap = b[DW-2:0] > a[DW-2:0];
  assign {sign_l, exp_l, frac_l} = swap ? b : a;
  assign {sign_s, exp_s, frac_s} = swap ? a : b;
  assign eff_sub   = sign_l ^ sign_s;
  assign eff_exp_l = (exp_l == '0) ? EXP_ONE : exp_l;
  assign eff_exp_s = (exp_s == '0) ? EXP_ONE : exp_s;
  assign shift     = eff_exp_l - eff_exp_s;

  assign ext_l   = {exp_l != '0, frac_l, 3'b000};
  assign ext_s   = {exp_s != '0, frac_s, 3'b000};
  assign sticky  = |(ext_s & ~({XW{1'b1}} << shift));
  assign aligned = (ext_s >> shift) | {{(XW-1){1'b0}}, sticky};
  assign sum_raw = eff_sub ? ({1'b0, ext_l} - {1'b0, aligned})
                           : ({1'b0, ext_l} + {1'b0, aligned});

  always_comb begin
    // NOTE: blocking assignments chain the normalisation steps within one evaluation; registers elsewhere use <=.
    norm  = sum_raw[XW-1:0];
    exp_n = {1'b0, eff_exp_l};
    if (sum_raw[XW]) begin
      norm  = sum_raw[XW:1] | {{(XW-1){1'b0}}, sum_raw[0]};
      exp_n = exp_n + EXN_ONE;
    end else begin
      for (int i = 0; i < XW; i++) begin
        if (!norm[XW-1] && (exp_n > EXN_ONE)) begin
          norm  = norm << 1;
          exp_n = exp_n - EXN_ONE;
        end
      end
    end
  end

  assign guard   = norm[2];
  assign rs      = |norm[1:0];
  assign inexact = guard | rs;

  always_comb begin
    case (rnd)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = inexact & ~sign_l;
      3'd3:    round_up = inexact & sign_l;
      3'd4:    round_up = guard;
      3'd5:    round_up = inexact;
      default: round_up = guard & (rs | norm[3]);
    endcase
  end

  assign rounded = {1'b0, norm[XW-1:3]} + {{MW{1'b0}}, round_up};
  // Exponent field is zero when the result stays subnormal after rounding.
  assign exp_r   = rounded[MW] ? (exp_n + EXN_ONE) : (rounded[MW-1] ? exp_n : '0);

  always_comb begin
    status = '0;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      z         = {1'b0, EXP_MAX, 1'b1, {(sig_width-1){1'b0}}};
      status[2] = 1'b1;
    end else if (a_inf || b_inf) begin
      z         = {sign_l, EXP_MAX, {sig_width{1'b0}}};
      status[1] = 1'b1;
    end else if (sum_raw == '0) begin
      z         = {(eff_sub ? (rnd == 3'd3) : sign_l), {(DW-1){1'b0}}};
      status[0] = 1'b1;
    end else if (exp_r >= EXN_MAX) begin
      status[4] = 1'b1;
      status[5] = 1'b1;
      if ((rnd == 3'd1) || ((rnd == 3'd2) && sign_l) || ((rnd == 3'd3) && !sign_l))
        z = {sign_l, EXP_MAX - EXP_ONE, {sig_width{1'b1}}};
      else
        z = {sign_l, EXP_MAX, {sig_width{1'b0}}};
    end else begin
      z         = {sign_l, exp_r[exp_width-1:0], rounded[sig_width-1:0]};
      status[5] = inexact;
    end
  end
endmodule

module fadd_stream_acc #(
  parameter int sig_width  = 7,
  parameter int exp_width  = 8,
  parameter int DATA_BIT   = sig_width + exp_width + 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BIT-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic [DATA_BIT-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef FADD_ACC_CNT_EN
  output logic [CNT_WIDTH-1:0] out_cnt,
`endif
  output logic                 busy,
  output logic                 err_ovf
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef FADD_ACC_CNT_EN
  localparam int EW = DATA_BIT + CNT_WIDTH;
`else
  localparam int EW = DATA_BIT;
  localparam int cnt_width_unused = CNT_WIDTH;
`endif
  localparam logic [AW:0] DEPTH_OCC = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nxt;

  logic [DATA_BIT-1:0] acc, add_b, sum;
  logic [7:0]          add_status_unused;
  logic                push, pop, full, push_ok, drop;
  logic [EW-1:0]       entry, head;
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         occ;

  assign add_b = in_valid ? in_data : '0;

  fp_add #(
    .sig_width(sig_width),
    .exp_width(exp_width)
  ) u_add (
    .a      (acc),
    .b      (add_b),
    .rnd    (3'b000),
    .z      (sum),
    .status (add_status_unused)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (in_last)       push      = 1'b1;
        else if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (in_last) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ACCUM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         acc <= '0;
    else if (in_last)  acc <= '0;
    else if (in_valid) acc <= sum;
  end

`ifdef FADD_ACC_CNT_EN
  logic [CNT_WIDTH-1:0] beats, beats_inc, push_cnt;

  assign beats_inc = (&beats) ? beats : beats + 1'b1;
  assign push_cnt  = in_valid ? beats_inc : beats;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         beats <= '0;
    else if (in_last)  beats <= '0;
    else if (in_valid) beats <= beats_inc;
  end

  assign entry    = {sum, push_cnt};
  assign out_data = out_valid ? head[EW-1 -: DATA_BIT] : '0;
  assign out_cnt  = out_valid ? head[CNT_WIDTH-1:0] : '0;
`else
  assign entry    = sum;
  assign out_data = out_valid ? head : '0;
`endif

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign out_valid = (occ != '0);
  assign full      = (occ == DEPTH_OCC);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);
  assign drop      = push & full & ~pop;
  assign head      = mem[rd_ptr];

  // NOTE: the storage array is not reset; out_valid gates it, so clearing the pointers is enough.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
      if (drop) err_ovf <= 1'b1;
    end
  end
endmodule
